// File: rtl/cpu_interlock_pkg.sv
// rtl/cpu_interlock_pkg.sv - shared widths, defaults and FSM states for cpu_interlock
package cpu_interlock_pkg;

  // Index width for a table of n entries, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int NREGS_DEF        = 16;
  localparam int IDX_W_DEF        = idx_w(NREGS_DEF);
  localparam int PEND_W_DEF       = 2;
  localparam int FLUSH_CYCLES_DEF = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

endpackage

// File: rtl/cpu_scoreboard.sv
// rtl/cpu_scoreboard.sv - per-register pending-write counters, load bits and hazard lookup (CPU_INTERLOCK_FWD_EN)
module cpu_scoreboard
  import cpu_interlock_pkg::*;
#(
  parameter int NREGS  = NREGS_DEF,
  parameter int PEND_W = PEND_W_DEF,
  parameter int IW     = IDX_W_DEF
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          i_rd_a,
  input  logic [IW-1:0] i_ri_a,
  input  logic          i_rd_b,
  input  logic [IW-1:0] i_ri_b,
  input  logic          i_we,
  input  logic [IW-1:0] i_wi,
  input  logic          i_inc,
  input  logic          i_load,
  input  logic          i_wb_valid,
  input  logic [IW-1:0] i_wb_index,
  output logic          o_hazard,
  output logic          o_overflow,
  output logic          o_busy,
  output logic          o_error
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic [PEND_W-1:0] r_pend [NREGS];
  logic [NREGS-1:0]  r_ld;
  logic              r_busy;
  logic              r_error;

  logic [PEND_W-1:0] w_pend_nxt [NREGS];
  logic [NREGS-1:0]  w_ld_nxt;
  logic              w_busy_nxt;
  logic              w_src_a;
  logic              w_src_b;
  logic              w_wb_same;

  // A write already at its cap can still issue when the same register retires this cycle.
  assign w_wb_same  = i_wb_valid && (i_wb_index == i_wi);
  assign o_overflow = i_we && (r_pend[i_wi] == PEND_MAX) && !w_wb_same;

`ifdef CPU_INTERLOCK_FWD_EN
  // ALU results are forwarded; only an outstanding load blocks a reader.
  assign w_src_a = (r_pend[i_ri_a] != '0) && r_ld[i_ri_a];
  assign w_src_b = (r_pend[i_ri_b] != '0) && r_ld[i_ri_b];
`else
  // No forwarding path: any outstanding write blocks a reader.
  assign w_src_a = (r_pend[i_ri_a] != '0);
  assign w_src_b = (r_pend[i_ri_b] != '0);
`endif

  assign o_hazard = (i_rd_a && w_src_a) || (i_rd_b && w_src_b);
  assign o_busy   = r_busy;
  assign o_error  = r_error;

  // Next counter/load-bit values: issue and retire on one index cancel out.
  always_comb begin
    w_busy_nxt = 1'b0;
    w_ld_nxt   = r_ld;
    for (int r = 0; r < NREGS; r++) begin
      w_pend_nxt[r] = r_pend[r];
      if (i_inc && (i_wi == IW'(r)) && !(i_wb_valid && (i_wb_index == IW'(r)))) begin
        w_pend_nxt[r] = r_pend[r] + PEND_W'(1);
      end else if (i_wb_valid && (i_wb_index == IW'(r)) && !(i_inc && (i_wi == IW'(r)))
                   && (r_pend[r] != '0)) begin
        w_pend_nxt[r] = r_pend[r] - PEND_W'(1);
      end
      if (i_inc && i_load && (i_wi == IW'(r))) begin
        w_ld_nxt[r] = 1'b1;
      end else if (w_pend_nxt[r] == '0) begin
        w_ld_nxt[r] = 1'b0;
      end
      w_busy_nxt = w_busy_nxt | (w_pend_nxt[r] != '0);
    end
  end

  // Scoreboard state; a retire against an empty counter latches the sticky error.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      for (int r = 0; r < NREGS; r++) begin
        r_pend[r] <= '0;
      end
      r_ld    <= '0;
      r_busy  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        r_pend[r] <= w_pend_nxt[r];
      end
      r_ld    <= w_ld_nxt;
      r_busy  <= w_busy_nxt;
      r_error <= r_error | (i_wb_valid && (r_pend[i_wb_index] == '0));
    end
  end

endmodule

// File: rtl/cpu_interlock.sv
// rtl/cpu_interlock.sv - moxie execute-stage interlock: stall/accept and branch flush FSM (CPU_INTERLOCK_FWD_EN)
module cpu_interlock
  import cpu_interlock_pkg::*;
#(
  parameter int NREGS        = NREGS_DEF,
  parameter int PEND_W       = PEND_W_DEF,
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    issue_valid_i,
  input  logic                    issue_rdA_i,
  input  logic [idx_w(NREGS)-1:0] issue_riA_i,
  input  logic                    issue_rdB_i,
  input  logic [idx_w(NREGS)-1:0] issue_riB_i,
  input  logic                    issue_we_i,
  input  logic [idx_w(NREGS)-1:0] issue_wi_i,
  input  logic                    issue_load_i,
  input  logic                    wb_valid_i,
  input  logic [idx_w(NREGS)-1:0] wb_index_i,
  input  logic                    branch_flag_i,
  output logic                    issue_accept_o,
  output logic                    stall_o,
  output logic                    flush_o,
  output logic                    busy_o,
  output logic                    error_o
);

  localparam int IW    = idx_w(NREGS);
  localparam int CNT_W = idx_w(FLUSH_CYCLES);
  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_flush;
  logic             w_hazard;
  logic             w_overflow;

  cpu_scoreboard #(
    .NREGS  (NREGS),
    .PEND_W (PEND_W),
    .IW     (IW)
  ) u_scoreboard (
    .i_clk      (clk_i),
    .i_rstn     (rst_i),
    .i_rd_a     (issue_rdA_i),
    .i_ri_a     (issue_riA_i),
    .i_rd_b     (issue_rdB_i),
    .i_ri_b     (issue_riB_i),
    .i_we       (issue_we_i),
    .i_wi       (issue_wi_i),
    .i_inc      (issue_accept_o && issue_we_i),
    .i_load     (issue_load_i),
    .i_wb_valid (wb_valid_i),
    .i_wb_index (wb_index_i),
    .o_hazard   (w_hazard),
    .o_overflow (w_overflow),
    .o_busy     (busy_o),
    .o_error    (error_o)
  );

  // The stall is purely combinational so decode sees it in the same cycle.
  assign stall_o        = issue_valid_i && (w_hazard || w_overflow || (r_state == ST_FLUSH));
  assign issue_accept_o = issue_valid_i && !stall_o;
  assign flush_o        = w_flush;

  // Flush sequencing: a branch (re)loads the counter; leave once it has drained.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_flush     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (branch_flag_i) begin
          w_state_nxt = ST_FLUSH;
          w_cnt_nxt   = FLUSH_LOAD;
        end
      end
      ST_FLUSH: begin
        w_flush = 1'b1;
        if (branch_flag_i) begin
          w_cnt_nxt = FLUSH_LOAD;
        end else if (r_cnt == '0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Flush FSM state and countdown registers.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

endmodule
